// File: rtl/conv_mac_serial_if.sv
// Handshake and data bundle for conv_mac_serial: sample loading, start/busy control
// and the valid/ready result byte stream.
interface conv_mac_serial_if #(
    parameter int DW = 8
);
    logic [DW-1:0] din;
    logic          wr_weight;
    logic          wr_pixel;
    logic          start;
    logic          busy;
    logic          res_valid;
    logic          res_ready;
    logic [7:0]    res_byte;
    logic          res_last;

    modport master (
        output din, wr_weight, wr_pixel, start, res_ready,
        input  busy, res_valid, res_byte, res_last
    );

    modport slave (
        input  din, wr_weight, wr_pixel, start, res_ready,
        output busy, res_valid, res_byte, res_last
    );
endinterface

// File: rtl/conv_mac_serial.sv
// Serial TAPS-point dot-product engine: one MAC per clock, result streamed LSB byte first.
// Define SIGNED_MAC_EN for two's-complement samples and a sign-extended result.
module conv_mac_serial #(
    parameter int DW   = 8,
    parameter int TAPS = 4
) (
    input logic             clk,
    input logic             rst_n,
    conv_mac_serial_if.slave bus
);
    localparam int AW = 2 * DW + $clog2(TAPS);
    localparam int NB = (AW + 7) / 8;
    localparam int RW = NB * 8;
    localparam int PW = 2 * DW;
    localparam int TW = $clog2(TAPS);
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t        state_reg, state_next;

    logic [DW-1:0] w_reg  [TAPS];
    logic [DW-1:0] x_reg  [TAPS];
    logic [DW-1:0] w_next [TAPS];
    logic [DW-1:0] x_next [TAPS];

    logic [AW-1:0] acc_reg, acc_next;
    logic [TW-1:0] tap_reg, tap_next;
    logic [IW-1:0] idx_reg, idx_next;

    logic          in_idle;
    logic          load_w;
    logic          load_x;
    logic          start_ok;
    logic          last_tap;
    logic          last_byte;
    logic          xfer;

    logic [DW-1:0] w_sel;
    logic [DW-1:0] x_sel;
    logic [PW-1:0] prod;
    logic [AW-1:0] prod_ext;
    logic [RW-1:0] res_ext;
    logic [7:0]    res_bytes [NB];

    assign in_idle   = (state_reg == IDLE);
    assign load_w    = in_idle && bus.wr_weight;
    assign load_x    = in_idle && bus.wr_pixel;
    assign start_ok  = in_idle && bus.start;
    assign last_tap  = (tap_reg == TW'(TAPS - 1));
    assign last_byte = (idx_reg == IW'(NB - 1));
    assign xfer      = (state_reg == OUT) && bus.res_ready;

    // New samples enter at the top tap, so the first sample written ends up in tap 0.
    generate
        for (genvar gi = 0; gi < TAPS; gi++) begin : g_shift
            if (gi == TAPS - 1) begin : g_head
                assign w_next[gi] = bus.din;
                assign x_next[gi] = bus.din;
            end else begin : g_body
                assign w_next[gi] = w_reg[gi + 1];
                assign x_next[gi] = x_reg[gi + 1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                w_reg[i] <= '0;
                x_reg[i] <= '0;
            end
        end else begin
            if (load_w) begin
                w_reg <= w_next;
            end
            if (load_x) begin
                x_reg <= x_next;
            end
        end
    end

    assign w_sel = w_reg[tap_reg];
    assign x_sel = x_reg[tap_reg];

`ifdef SIGNED_MAC_EN
    logic signed [PW-1:0] w_wide;
    logic signed [PW-1:0] x_wide;

    assign w_wide   = PW'($signed(w_sel));
    assign x_wide   = PW'($signed(x_sel));
    assign prod     = w_wide * x_wide;
    assign prod_ext = AW'($signed(prod));
    assign res_ext  = RW'($signed(acc_reg));
`else
    assign prod     = PW'(w_sel) * PW'(x_sel);
    assign prod_ext = AW'(prod);
    assign res_ext  = RW'(acc_reg);
`endif

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_bytes
            assign res_bytes[gi] = res_ext[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = MAC;
                end
            end
            MAC: begin
                if (last_tap) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                if (xfer && last_byte) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (state_reg != IDLE);
        bus.res_valid = (state_reg == OUT);
        bus.res_last  = (state_reg == OUT) && last_byte;
        bus.res_byte  = (state_reg == OUT) ? res_bytes[idx_reg] : 8'h00;
    end

    // Accumulator and indices only move in their own phase, so a held res_ready=0 freezes the output.
    always_comb begin
        acc_next = acc_reg;
        tap_next = tap_reg;
        idx_next = idx_reg;
        case (state_reg)
            IDLE: begin
                if (start_ok) begin
                    acc_next = '0;
                    tap_next = '0;
                    idx_next = '0;
                end
            end
            MAC: begin
                acc_next = acc_reg + prod_ext;
                tap_next = last_tap ? '0 : tap_reg + 1'b1;
                if (last_tap) begin
                    idx_next = '0;
                end
            end
            OUT: begin
                if (xfer) begin
                    idx_next = last_byte ? '0 : idx_reg + 1'b1;
                end
            end
            default: begin
                tap_next = '0;
                idx_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
            tap_reg <= '0;
            idx_reg <= '0;
        end else begin
            acc_reg <= acc_next;
            tap_reg <= tap_next;
            idx_reg <= idx_next;
        end
    end
endmodule

// File: tb/tb_conv_mac_serial.sv
// Directed bench for conv_mac_serial (DW=8, TAPS=4) with a byte scoreboard fed by a dot-product model.
module tb_conv_mac_serial;
    localparam int DW   = 8;
    localparam int TAPS = 4;
    localparam int NB   = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    conv_mac_serial_if #(.DW(DW)) bus ();

    conv_mac_serial #(.DW(DW), .TAPS(TAPS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0] b;
        logic       last;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [7:0] mw [TAPS];
    logic [7:0] mx [TAPS];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Byte i of wv/xv is written i-th, so it lands in tap i.
    task automatic load(input logic [31:0] wv, input logic [31:0] xv);
        for (int i = 0; i < TAPS; i++) begin
            @(negedge clk);
            bus.din = wv[8*i +: 8]; bus.wr_weight = 1'b1; bus.wr_pixel = 1'b0;
            for (int j = 0; j < TAPS - 1; j++) mw[j] = mw[j + 1];
            mw[TAPS-1] = wv[8*i +: 8];
        end
        for (int i = 0; i < TAPS; i++) begin
            @(negedge clk);
            bus.din = xv[8*i +: 8]; bus.wr_weight = 1'b0; bus.wr_pixel = 1'b1;
            for (int j = 0; j < TAPS - 1; j++) mx[j] = mx[j + 1];
            mx[TAPS-1] = xv[8*i +: 8];
        end
        @(negedge clk);
        bus.wr_weight = 1'b0; bus.wr_pixel = 1'b0; bus.din = '0;
    endtask

    task automatic push_expected();
        logic signed [31:0] s;
        exp_t e;
        s = 0;
        for (int i = 0; i < TAPS; i++) begin
`ifdef SIGNED_MAC_EN
            s = s + $signed(mw[i]) * $signed(mx[i]);
`else
            s = s + mw[i] * mx[i];
`endif
        end
        for (int b = 0; b < NB; b++) begin
            e.b = s[8*b +: 8];
            e.last = (b == NB - 1);
            sb.push_back(e);
        end
    endtask

    // Returns at the negedge where res_valid is first seen; lockout pokes writes/start during MAC.
    task automatic start_and_wait(input bit lockout);
        int lat;
        lat = 0;
        @(negedge clk);
        bus.start = 1'b1;
        forever begin
            @(negedge clk);
            lat++;
            bus.start = 1'b0;
            if (lat == 1) check("busy_after_start", bus.busy, 1);
            if (lockout && (lat == 2 || lat == 3)) begin
                bus.din = 8'h00; bus.wr_weight = 1'b1; bus.start = 1'b1;
            end
            if (lockout && lat == 4) begin
                bus.wr_weight = 1'b0; bus.start = 1'b0;
            end
            if (bus.res_valid) break;
            if (lat > 40) begin
                check("valid_timeout", 0, 1);
                break;
            end
        end
        check("first_valid_latency", lat, TAPS + 1);
    endtask

    task automatic collect(input int stall_at, input int stall_n);
        int   stalled;
        int   guard;
        int   k;
        exp_t e;
        stalled = 0; guard = 0; k = 0;
        while (sb.size() > 0 && guard < 100) begin
            guard++;
            if (bus.res_valid) begin
                e = sb[0];
                if (k == stall_at && stalled < stall_n) begin
                    bus.res_ready = 1'b0;
                    check("stall_byte", bus.res_byte, e.b);
                    check("stall_last", bus.res_last, e.last);
                    check("stall_busy", bus.busy, 1);
                    stalled++;
                end else begin
                    bus.res_ready = 1'b1;
                    void'(sb.pop_front());
                    $display("xfer %0d byte=%02h last=%0b exp_byte=%02h exp_last=%0b",
                             k, bus.res_byte, bus.res_last, e.b, e.last);
                    check("res_byte", bus.res_byte, e.b);
                    check("res_last", bus.res_last, e.last);
                    k++;
                end
            end
            @(negedge clk);
        end
        if (guard >= 100) check("collect_timeout", 0, 1);
        bus.res_ready = 1'b1;
        check("busy_done", bus.busy, 0);
        check("valid_done", bus.res_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.din = '0; bus.wr_weight = 1'b0; bus.wr_pixel = 1'b0;
        bus.start = 1'b0; bus.res_ready = 1'b1;
        for (int i = 0; i < TAPS; i++) begin
            mw[i] = '0; mx[i] = '0;
        end
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_valid", bus.res_valid, 0);
        check("rst_byte", bus.res_byte, 0);
        check("rst_last", bus.res_last, 0);
        rst_n = 1'b1;

        // Basic: 1,2,3,4 . 10,20,30,40 = 300
        load(32'h04030201, {8'd40, 8'd30, 8'd20, 8'd10});
        push_expected();
        start_and_wait(1'b0);
        collect(-1, 0);

        // Backpressure at byte 1, recompute without reload
        push_expected();
        start_and_wait(1'b0);
        collect(1, 5);

        // Busy lockout: writes and start during MAC must be ignored
        push_expected();
        start_and_wait(1'b1);
        collect(-1, 0);
        repeat (8) @(negedge clk);
        check("no_second_run_valid", bus.res_valid, 0);
        check("no_second_run_busy", bus.busy, 0);
        push_expected();
        start_and_wait(1'b0);
        collect(-1, 0);

        // Max: all 0xFF
        load(32'hFFFFFFFF, 32'hFFFFFFFF);
        push_expected();
        start_and_wait(1'b0);
        collect(-1, 0);

        // Mode: weights 0xFF, pixels 0x02
        load(32'hFFFFFFFF, 32'h02020202);
        push_expected();
        start_and_wait(1'b0);
        collect(-1, 0);

        // Reset mid-OUT after byte 0
        push_expected();
        start_and_wait(1'b0);
        bus.res_ready = 1'b1;
        check("pre_reset_byte0", bus.res_byte, sb[0].b);
        @(negedge clk);
        bus.res_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", bus.res_valid, 0);
        check("mid_rst_byte", bus.res_byte, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_last", bus.res_last, 0);
        sb.delete();
        for (int i = 0; i < TAPS; i++) begin
            mw[i] = '0; mx[i] = '0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.res_ready = 1'b1;
        push_expected();
        start_and_wait(1'b0);
        collect(-1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
